ex_mem_reg: RTL

Pipeline register between the execute stage (ALU) and the memory stage. Captures the 32-bit ALU result, store data, destination register and memory/write-back control bits each cycle, supporting stall and flush from the hazard unit. Also produces the EX/MEM forwarding tap, a retired-instruction counter and a sticky illegal-control error flag.

---
 rtl/ex_mem_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU result, store data, destination and
// memory/write-back controls with stall/flush, plus forwarding tap, retired count and error flag.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              fwd_en_o,
    output logic [31:0]       retired_o,
    output logic              err_o
);

    logic              valid_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] wdata_q;
    logic [REG_AW-1:0] rd_q;
    logic              regwrite_q;
    logic              memtoreg_q;
    logic              memread_q;
    logic              memwrite_q;
    logic [31:0]       retired_q;
    logic              err_q;

    logic              illegal;
    logic              accept;
    logic [31:0]       retired_d;

    // A load and a store in the same instruction is not encodable; it retires as a bubble.
    assign illegal   = valid_i & memread_i & memwrite_i;
    assign accept    = valid_i & ~illegal;
    assign retired_d = retired_q + {31'd0, accept};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            retired_q    <= '0;
            err_q        <= 1'b0;
        end else if (flush_i) begin
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
        end else if (!stall_i) begin
            valid_q      <= accept;
            alu_result_q <= alu_result_i;
            wdata_q      <= wdata_i;
            rd_q         <= rd_i;
            // Writes to x0 are dropped here so later stages never see them.
            regwrite_q   <= accept & regwrite_i & (rd_i != '0);
            memtoreg_q   <= accept & memtoreg_i;
            memread_q    <= accept & memread_i;
            memwrite_q   <= accept & memwrite_i;
            retired_q    <= retired_d;
            if (illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign valid_o      = valid_q;
    assign alu_result_o = alu_result_q;
    assign wdata_o      = wdata_q;
    assign rd_o         = rd_q;
    assign regwrite_o   = regwrite_q;
    assign memtoreg_o   = memtoreg_q;
    assign memread_o    = memread_q;
    assign memwrite_o   = memwrite_q;
    assign fwd_en_o     = valid_q & regwrite_q & (rd_q != '0);
    assign retired_o    = retired_q;
    assign err_o        = err_q;

endmodule
